// File: rtl/esm_issue_scheduler.sv
// Out-of-order issue scheduler: slot allocation, dependency/age matrices,
// oldest-ready selection into a single issue register, completion wake-up.
module esm_issue_scheduler #(
  parameter  int Instr_word_size = 32,
  parameter  int regnum          = 32,
  parameter  int bs              = 16,
  localparam int reg_addr_bits   = $clog2(regnum),
  localparam int bs_bits         = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] in_instr,
  input  logic                       in_alusrc,
  input  logic                       in_regwrite,
  output logic [bs_bits-1:0]         alloc_index,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [bs_bits-1:0]         iss_index,
  output logic [Instr_word_size-1:0] iss_instr,
  input  logic                       cmp_valid,
  input  logic [bs_bits-1:0]         cmp_index,
  output logic [bs_bits:0]           occupancy
);

  typedef logic [reg_addr_bits-1:0] reg_t;

  logic [bs-1:0]              valid_q, valid_d, issued_q, issued_d;
  logic [Instr_word_size-1:0] instr_q [bs];
  logic [Instr_word_size-1:0] instr_d [bs];
  reg_t                       src1_q [bs], src1_d [bs];
  reg_t                       src2_q [bs], src2_d [bs];
  reg_t                       dst_q  [bs], dst_d  [bs];
  logic [bs-1:0]              dep_q  [bs], dep_d  [bs];
  logic [bs-1:0]              age_q  [bs], age_d  [bs];
  logic [bs_bits:0]           occ_q, occ_d;
  logic                       iss_valid_q, iss_valid_d;
  logic [bs_bits-1:0]         iss_index_q, iss_index_d;
  logic [Instr_word_size-1:0] iss_instr_q, iss_instr_d;

  reg_t               in_src1_s, in_src2_s, in_dst_s;
  logic [bs-1:0]      cand_s, new_dep_s;
  logic               sel_found_s, in_ready_s, alloc_fire_s, cmp_ok_s, load_en_s;
  logic [bs_bits-1:0] sel_idx_s, alloc_idx_s;

  assign in_src1_s    = in_instr[15 +: reg_addr_bits];
  assign in_src2_s    = in_alusrc   ? in_instr[20 +: reg_addr_bits] : '0;
  assign in_dst_s     = in_regwrite ? in_instr[7 +: reg_addr_bits]  : '0;
  assign in_ready_s   = (occ_q < (bs_bits + 1)'(bs));
  assign alloc_fire_s = in_valid && in_ready_s;
  // A completion only counts for a slot that is both valid and already issued.
  assign cmp_ok_s     = cmp_valid && valid_q[cmp_index] && issued_q[cmp_index];
  assign load_en_s    = !iss_valid_q || iss_ready;

  // Oldest-ready selection, lowest free slot and dependency row for the incoming instruction
  always_comb begin
    cand_s      = '0;
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    alloc_idx_s = '0;
    new_dep_s   = '0;
    for (int i = 0; i < bs; i++) begin
      cand_s[i] = valid_q[i] && !issued_q[i] && (dep_q[i] == '0);
    end
    for (int i = 0; i < bs; i++) begin
      sel_idx_s   = (cand_s[i] && ((age_q[i] & cand_s) == '0)) ? bs_bits'(i) : sel_idx_s;
      sel_found_s = sel_found_s | (cand_s[i] && ((age_q[i] & cand_s) == '0));
    end
    for (int i = bs - 1; i >= 0; i--) begin
      alloc_idx_s = !valid_q[i] ? bs_bits'(i) : alloc_idx_s;
    end
    for (int j = 0; j < bs; j++) begin
      new_dep_s[j] = valid_q[j] && (dst_q[j] != '0) &&
                     ((dst_q[j] == in_src1_s) || (dst_q[j] == in_src2_s) || (dst_q[j] == in_dst_s));
    end
  end

  // Next-state for slots, issue register and occupancy
  always_comb begin
    valid_d     = valid_q;
    issued_d    = issued_q;
    instr_d     = instr_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    dst_d       = dst_q;
    dep_d       = dep_q;
    age_d       = age_q;
    occ_d       = occ_q;
    iss_valid_d = iss_valid_q;
    iss_index_d = iss_index_q;
    iss_instr_d = iss_instr_q;

    if (load_en_s) begin
      iss_valid_d = sel_found_s;
      if (sel_found_s) begin
        iss_index_d         = sel_idx_s;
        iss_instr_d         = instr_q[sel_idx_s];
        issued_d[sel_idx_s] = 1'b1;
      end else begin
        iss_index_d = iss_index_q;
      end
    end else begin
      iss_valid_d = iss_valid_q;
    end

    if (alloc_fire_s) begin
      valid_d[alloc_idx_s]  = 1'b1;
      issued_d[alloc_idx_s] = 1'b0;
      instr_d[alloc_idx_s]  = in_instr;
      src1_d[alloc_idx_s]   = in_src1_s;
      src2_d[alloc_idx_s]   = in_src2_s;
      dst_d[alloc_idx_s]    = in_dst_s;
      dep_d[alloc_idx_s]    = new_dep_s;
      age_d[alloc_idx_s]    = valid_q;
    end else begin
      occ_d = occ_q;
    end

    // Column clear runs after the allocation write so a same-cycle freed slot is dropped from the new row.
    if (cmp_ok_s) begin
      valid_d[cmp_index]  = 1'b0;
      issued_d[cmp_index] = 1'b0;
      for (int i = 0; i < bs; i++) begin
        dep_d[i][cmp_index] = 1'b0;
        age_d[i][cmp_index] = 1'b0;
      end
    end else begin
      occ_d = occ_q;
    end

    case ({alloc_fire_s, cmp_ok_s})
      2'b10:   occ_d = occ_q + (bs_bits + 1)'(1);
      2'b01:   occ_d = occ_q - (bs_bits + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= '0;
      issued_q    <= '0;
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_index_q <= '0;
      iss_instr_q <= '0;
      for (int i = 0; i < bs; i++) begin
        instr_q[i] <= '0;
        src1_q[i]  <= '0;
        src2_q[i]  <= '0;
        dst_q[i]   <= '0;
        dep_q[i]   <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      issued_q    <= issued_d;
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      iss_index_q <= iss_index_d;
      iss_instr_q <= iss_instr_d;
      for (int i = 0; i < bs; i++) begin
        instr_q[i] <= instr_d[i];
        src1_q[i]  <= src1_d[i];
        src2_q[i]  <= src2_d[i];
        dst_q[i]   <= dst_d[i];
        dep_q[i]   <= dep_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign alloc_index = alloc_idx_s;
  assign iss_valid   = iss_valid_q;
  assign iss_index   = iss_index_q;
  assign iss_instr   = iss_instr_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Scoreboard bench for esm_issue_scheduler: expected issues are queued at
// stimulus time and popped on every issue handshake.
module tb_esm_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic        in_alusrc = 1'b0;
  logic        in_regwrite = 1'b0;
  logic [3:0]  alloc_index;
  logic        iss_valid;
  logic        iss_ready = 1'b1;
  logic [3:0]  iss_index;
  logic [31:0] iss_instr;
  logic        cmp_valid = 1'b0;
  logic [3:0]  cmp_index = 4'd0;
  logic [4:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] sb[$];

  esm_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_alusrc(in_alusrc), .in_regwrite(in_regwrite), .alloc_index(alloc_index),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_index(iss_index), .iss_instr(iss_instr),
    .cmp_valid(cmp_valid), .cmp_index(cmp_index), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  // Compare any handshake about to happen against the scoreboard, then advance one cycle.
  task automatic step();
    logic [35:0] e;
    if (iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_issue", 64'(iss_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("iss_index", 64'(iss_index), 64'(e[35:32]));
        check_val("iss_instr", 64'(iss_instr), 64'(e[31:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [31:0] ins, input logic a, input logic w);
    in_valid = 1'b1; in_instr = ins; in_alusrc = a; in_regwrite = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic complete(input int idx);
    cmp_valid = 1'b1; cmp_index = 4'(idx);
    step();
    cmp_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic complete_all();
    for (int k = 0; k < 16; k++) complete(k);
    check_val("occ_empty", 64'(occupancy), 64'd0);
  endtask

  initial begin
    logic [31:0] i0, i1, x, y, r, t;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_iss_valid", 64'(iss_valid), 64'd0);
    check_val("rst_occ", 64'(occupancy), 64'd0);
    check_val("rst_alloc_idx", 64'(alloc_index), 64'd0);

    // Independent pair
    i0 = mk(1, 2, 3);
    i1 = mk(4, 5, 6);
    in_valid = 1'b1; in_instr = i0; in_alusrc = 1'b1; in_regwrite = 1'b1;
    check_val("pair_alloc0", 64'(alloc_index), 64'd0);
    sb.push_back({4'd0, i0});
    step();
    in_instr = i1;
    check_val("pair_alloc1", 64'(alloc_index), 64'd1);
    check_val("pair_lat_early", 64'(iss_valid), 64'd0);
    sb.push_back({4'd1, i1});
    step();
    in_valid = 1'b0;
    check_val("pair_lat_valid", 64'(iss_valid), 64'd1);
    check_val("pair_lat_index", 64'(iss_index), 64'd0);
    wait_drain(10);
    complete(0);
    complete(1);
    check_val("pair_occ", 64'(occupancy), 64'd0);

    // RAW chain
    i0 = mk(1, 2, 0);
    i1 = mk(3, 1, 0);
    sb.push_back({4'd0, i0});
    alloc(i0, 1'b0, 1'b1);
    alloc(i1, 1'b0, 1'b1);
    wait_drain(10);
    repeat (3) step();
    check_val("raw_blocked", 64'(iss_valid), 64'd0);
    sb.push_back({4'd1, i1});
    complete(0);
    check_val("raw_wake_early", 64'(iss_valid), 64'd0);
    step();
    check_val("raw_wake_valid", 64'(iss_valid), 64'd1);
    check_val("raw_wake_index", 64'(iss_index), 64'd1);
    wait_drain(10);
    complete(1);

    // Backpressure
    iss_ready = 1'b0;
    i0 = mk(7, 8, 0);
    i1 = mk(9, 10, 0);
    sb.push_back({4'd0, i0});
    sb.push_back({4'd1, i1});
    alloc(i0, 1'b0, 1'b1);
    alloc(i1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check_val("bp_index", 64'(iss_index), 64'd0);
      check_val("bp_instr", 64'(iss_instr), 64'(i0));
      step();
    end
    iss_ready = 1'b1;
    wait_drain(10);
    complete(0);
    complete(1);

    // Full and wrap
    in_alusrc = 1'b0; in_regwrite = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_instr = mk(k + 1, 0, 0);
      check_val("full_alloc_idx", 64'(alloc_index), 64'(k));
      sb.push_back({4'(k), mk(k + 1, 0, 0)});
      step();
    end
    in_instr = mk(30, 0, 0);
    check_val("full_occ", 64'(occupancy), 64'd16);
    check_val("full_in_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    check_val("full_ignore", 64'(occupancy), 64'd16);
    wait_drain(40);
    complete(5);
    check_val("wrap_in_ready", 64'(in_ready), 64'd1);
    check_val("wrap_alloc_idx", 64'(alloc_index), 64'd5);
    check_val("wrap_occ", 64'(occupancy), 64'd15);
    x = mk(21, 5, 0);
    y = mk(22, 5, 0);
    alloc(x, 1'b0, 1'b1);
    complete(3);
    check_val("wrap_alloc_idx3", 64'(alloc_index), 64'd3);
    alloc(y, 1'b0, 1'b1);
    repeat (2) step();
    check_val("wrap_blocked", 64'(iss_valid), 64'd0);
    sb.push_back({4'd5, x});
    sb.push_back({4'd3, y});
    complete(4);
    wait_drain(10);
    complete_all();

    // Simultaneous completion and allocation
    for (int k = 0; k < 3; k++) begin
      sb.push_back({4'(k), mk(10 + k, 0, 0)});
      alloc(mk(10 + k, 0, 0), 1'b0, 1'b1);
    end
    wait_drain(10);
    r = mk(13, 12, 0);
    in_valid = 1'b1; in_instr = r; cmp_valid = 1'b1; cmp_index = 4'd2;
    check_val("sim_alloc_idx", 64'(alloc_index), 64'd3);
    sb.push_back({4'd3, r});
    step();
    in_valid = 1'b0; cmp_valid = 1'b0;
    check_val("sim_occ", 64'(occupancy), 64'd3);
    step();
    check_val("sim_issue_valid", 64'(iss_valid), 64'd1);
    check_val("sim_issue_index", 64'(iss_index), 64'd3);
    wait_drain(10);
    t = mk(14, 13, 0);
    check_val("spur_alloc_idx", 64'(alloc_index), 64'd2);
    alloc(t, 1'b0, 1'b1);
    complete(2);
    check_val("spur_unissued_occ", 64'(occupancy), 64'd4);
    complete(7);
    check_val("spur_invalid_occ", 64'(occupancy), 64'd4);
    repeat (2) step();
    check_val("spur_blocked", 64'(iss_valid), 64'd0);
    sb.push_back({4'd2, t});
    complete(3);
    wait_drain(10);
    complete_all();

    // Reset mid-operation discards the held issue
    iss_ready = 1'b0;
    alloc(mk(15, 0, 0), 1'b0, 1'b1);
    step();
    check_val("mid_held", 64'(iss_valid), 64'd1);
    rst = 1'b0;
    cmp_valid = 1'b1; cmp_index = 4'd0;
    step();
    rst = 1'b1; cmp_valid = 1'b0;
    check_val("mid_iss_valid", 64'(iss_valid), 64'd0);
    check_val("mid_occ", 64'(occupancy), 64'd0);
    check_val("mid_in_ready", 64'(in_ready), 64'd1);
    check_val("mid_alloc_idx", 64'(alloc_index), 64'd0);
    iss_ready = 1'b1;
    step();
    check_val("sb_final", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
